// File: rtl/grf_pkg.sv
// Shared types and defaults for the multi-port general register file.
// Optional write trace is enabled with the GRF_TRACE_EN macro.
package grf_pkg;

    typedef enum logic {
        CLEAR = 1'b0,
        READY = 1'b1
    } grf_state_e;

    localparam int GRF_DATA_W = 32;
    localparam int GRF_ADDR_W = 5;
    localparam int GRF_NUM_RD = 2;
    localparam int GRF_REG0   = 0;

endpackage

// File: rtl/grf_rd_port.sv
// One register-file read port: write bypass and busy-bit forwarding.
// Register 0 and the initialisation sweep both force a zero result.
module grf_rd_port
    import grf_pkg::*;
#(
    parameter int DATA_W = GRF_DATA_W,
    parameter int ADDR_W = GRF_ADDR_W
) (
    input  logic              ready,
    input  logic [ADDR_W-1:0] ra,
    input  logic [DATA_W-1:0] arr_data,
    input  logic              busy_bit,
    input  logic              we,
    input  logic [ADDR_W-1:0] wa,
    input  logic [DATA_W-1:0] wd,
    input  logic              set_en,
    input  logic [ADDR_W-1:0] set_addr,
    output logic [DATA_W-1:0] rd,
    output logic              rbusy
);

    localparam logic [ADDR_W-1:0] REG0 = ADDR_W'(GRF_REG0);

    logic hit_wr;
    logic hit_set;

    always_comb begin
        hit_wr  = ready && we && (wa == ra) && (wa != REG0);
        hit_set = ready && set_en && (set_addr == ra) && (set_addr != REG0);
        rd      = '0;
        rbusy   = 1'b0;
        if (ready && (ra != REG0)) begin
            rd = hit_wr ? wd : arr_data;
            // A pending set on the same register outranks the clear.
            rbusy = (hit_wr && !hit_set) ? 1'b0 : busy_bit;
        end
    end

endmodule

// File: rtl/mp_grf.sv
// Multi-read-port register file with busy scoreboard and clear sweep.
// Define GRF_TRACE_EN to print every accepted write with its pc.
module mp_grf
    import grf_pkg::*;
#(
    parameter int DATA_W = GRF_DATA_W,
    parameter int ADDR_W = GRF_ADDR_W,
    parameter int NUM_RD = GRF_NUM_RD
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_RD*ADDR_W-1:0] ra,
    output logic [NUM_RD*DATA_W-1:0] rd,
    output logic [NUM_RD-1:0]        rbusy,
    input  logic                     we,
    input  logic [ADDR_W-1:0]        wa,
    input  logic [DATA_W-1:0]        wd,
    input  logic                     set_en,
    input  logic [ADDR_W-1:0]        set_addr,
    input  logic [31:0]              pc,
    output logic                     ready
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] REG0 = ADDR_W'(GRF_REG0);
    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W-1:0] CNT0 = ADDR_W'(1);

    grf_state_e        state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic [DEPTH-1:0]  busy_q, busy_d;
    logic [DATA_W-1:0] mem_q [DEPTH];

    logic              mem_we;
    logic [ADDR_W-1:0] mem_wa;
    logic [DATA_W-1:0] mem_wd;
    logic              wr_acc;
    logic              set_acc;

    assign ready   = (state_q == READY);
    assign wr_acc  = ready && we && (wa != REG0);
    assign set_acc = ready && set_en && (set_addr != REG0);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        mem_we  = 1'b0;
        mem_wa  = wa;
        mem_wd  = wd;
        unique case (state_q)
            CLEAR: begin
                mem_we = 1'b1;
                mem_wa = cnt_q;
                mem_wd = '0;
                if (cnt_q == LAST) begin
                    state_d = READY;
                end else begin
                    cnt_d = cnt_q + CNT0;
                end
            end
            READY: begin
                mem_we = wr_acc;
            end
            default: begin
                state_d = CLEAR;
            end
        endcase
    end

    always_comb begin
        busy_d = busy_q;
        if (wr_acc) begin
            busy_d[wa] = 1'b0;
        end
        if (set_acc) begin
            busy_d[set_addr] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= CLEAR;
            cnt_q   <= CNT0;
            busy_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
        end
    end

    // Data array has no reset; the CLEAR sweep zeroes it instead.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[mem_wa] <= mem_wd;
        end
    end

    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        logic [ADDR_W-1:0] ra_k;
        assign ra_k = ra[k*ADDR_W +: ADDR_W];

        grf_rd_port #(
            .DATA_W (DATA_W),
            .ADDR_W (ADDR_W)
        ) u_port (
            .ready    (ready),
            .ra       (ra_k),
            .arr_data (mem_q[ra_k]),
            .busy_bit (busy_q[ra_k]),
            .we       (we),
            .wa       (wa),
            .wd       (wd),
            .set_en   (set_en),
            .set_addr (set_addr),
            .rd       (rd[k*DATA_W +: DATA_W]),
            .rbusy    (rbusy[k])
        );
    end

`ifdef GRF_TRACE_EN
    always @(posedge clk) begin
        if (wr_acc) begin
            $display("%0t@%h: $%0d <= %h", $time, pc, wa, wd);
        end
    end
`else
    logic unused_pc;
    assign unused_pc = ^pc;
`endif

endmodule

// File: tb/tb_mp_grf.sv
// Scoreboard bench for mp_grf: default instance plus a 4-port 3-bit one.
// Stimulus pushes expectations; the negedge monitor pops and compares.
module tb_mp_grf;

    typedef struct {
        string          name;
        int             sig;
        logic [127:0]   exp;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;

    logic         clk = 1'b0;
    logic         reset;
    logic [9:0]   ra;
    logic [63:0]  rd;
    logic [1:0]   rbusy;
    logic         we;
    logic [4:0]   wa;
    logic [31:0]  wd;
    logic         set_en;
    logic [4:0]   set_addr;
    logic [31:0]  pc;
    logic         ready;

    logic         reset2;
    logic [11:0]  ra2;
    logic [127:0] rd2;
    logic [3:0]   rbusy2;
    logic         we2;
    logic [2:0]   wa2;
    logic [31:0]  wd2;
    logic         set_en2;
    logic [2:0]   set_addr2;
    logic         ready2;

    always #5 clk = ~clk;

    mp_grf dut (
        .clk      (clk),
        .reset    (reset),
        .ra       (ra),
        .rd       (rd),
        .rbusy    (rbusy),
        .we       (we),
        .wa       (wa),
        .wd       (wd),
        .set_en   (set_en),
        .set_addr (set_addr),
        .pc       (pc),
        .ready    (ready)
    );

    mp_grf #(
        .DATA_W (32),
        .ADDR_W (3),
        .NUM_RD (4)
    ) dut2 (
        .clk      (clk),
        .reset    (reset2),
        .ra       (ra2),
        .rd       (rd2),
        .rbusy    (rbusy2),
        .we       (we2),
        .wa       (wa2),
        .wd       (wd2),
        .set_en   (set_en2),
        .set_addr (set_addr2),
        .pc       (pc),
        .ready    (ready2)
    );

    localparam int S_READY  = 0;
    localparam int S_RD     = 1;
    localparam int S_RBUSY  = 2;
    localparam int S_READY2 = 3;
    localparam int S_RD2    = 4;
    localparam int S_RBUSY2 = 5;

    function automatic logic [127:0] actual(input int s);
        case (s)
            S_READY:  return {127'h0, ready};
            S_RD:     return {64'h0, rd};
            S_RBUSY:  return {126'h0, rbusy};
            S_READY2: return {127'h0, ready2};
            S_RD2:    return rd2;
            S_RBUSY2: return {124'h0, rbusy2};
            default:  return {128{1'bx}};
        endcase
    endfunction

    task automatic push(input string n, input int s, input logic [127:0] v);
        exp_t e;
        e.name = n;
        e.sig  = s;
        e.exp  = v;
        sb.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        pc = pc + 32'd4;
    endtask

    always @(negedge clk) begin
        exp_t e;
        logic [127:0] act;
        while (sb.size() > 0) begin
            e   = sb.pop_front();
            act = actual(e.sig);
            checks++;
            if (act !== e.exp) begin
                failures++;
                $display("FAIL %s: got %h expected %h", e.name, act, e.exp);
            end
        end
    end

    initial begin
        reset = 1'b0;  reset2 = 1'b0;
        ra = {5'd4, 5'd1};
        we = 1'b1;  wa = 5'd4;  wd = 32'hFFFF_FFFF;
        set_en = 1'b1;  set_addr = 5'd4;
        pc = 32'h1000;
        ra2 = {4{3'd3}};
        we2 = 1'b0;  wa2 = 3'd0;  wd2 = 32'h0;
        set_en2 = 1'b0;  set_addr2 = 3'd0;

        repeat (3) tick();
        push("rst_ready", S_READY, 128'h0);
        push("rst_rd", S_RD, 128'h0);
        push("rst_rbusy", S_RBUSY, 128'h0);
        push("rst_ready2", S_READY2, 128'h0);

        // Full sweep; writes and sets issued during CLEAR must be dropped.
        reset = 1'b1;
        for (int i = 1; i <= 32; i++) begin
            tick();
            if (i == 30) begin
                we = 1'b0;
                set_en = 1'b0;
            end
            push("sweep_ready", S_READY, (i >= 31) ? 128'h1 : 128'h0);
            if (i < 31) begin
                push("sweep_rd", S_RD, 128'h0);
                push("sweep_rbusy", S_RBUSY, 128'h0);
            end
        end

        for (int a = 1; a < 32; a++) begin
            tick();
            ra = {5'(a), 5'(a)};
            push("zero_rd", S_RD, 128'h0);
            push("zero_rbusy", S_RBUSY, 128'h0);
        end

        tick();
        we = 1'b1;  wa = 5'd5;  wd = 32'hDEAD_BEEF;
        ra = {5'd6, 5'd5};
        push("bypass_rd", S_RD, {64'h0, 32'h0, 32'hDEAD_BEEF});
        tick();
        we = 1'b0;
        ra = {5'd5, 5'd5};
        push("stored_rd", S_RD, {64'h0, 32'hDEAD_BEEF, 32'hDEAD_BEEF});

        tick();
        we = 1'b1;  wa = 5'd0;  wd = 32'h1234;
        set_en = 1'b1;  set_addr = 5'd0;
        ra = 10'd0;
        push("reg0_rd", S_RD, 128'h0);
        push("reg0_rbusy", S_RBUSY, 128'h0);
        tick();
        we = 1'b0;  set_en = 1'b0;
        push("reg0_rd_after", S_RD, 128'h0);
        push("reg0_rbusy_after", S_RBUSY, 128'h0);

        tick();
        set_en = 1'b1;  set_addr = 5'd7;
        ra = {5'd8, 5'd7};
        push("set_cycle", S_RBUSY, 128'h0);
        tick();
        set_en = 1'b0;
        push("set_next", S_RBUSY, 128'h1);
        tick();
        we = 1'b1;  wa = 5'd7;  wd = 32'h77;
        push("clr_cycle", S_RBUSY, 128'h0);
        push("clr_rd", S_RD, {64'h0, 32'h0, 32'h77});
        tick();
        we = 1'b0;
        push("clr_next", S_RBUSY, 128'h0);
        push("clr_rd_next", S_RD, {64'h0, 32'h0, 32'h77});
        tick();
        set_en = 1'b1;  set_addr = 5'd7;
        tick();
        we = 1'b1;  wa = 5'd7;  wd = 32'h99;
        push("setclr_cycle", S_RBUSY, 128'h1);
        push("setclr_rd", S_RD, {64'h0, 32'h0, 32'h99});
        tick();
        we = 1'b0;  set_en = 1'b0;
        push("setclr_next", S_RBUSY, 128'h1);
        push("setclr_rd_next", S_RD, {64'h0, 32'h0, 32'h99});
        tick();
        we = 1'b1;  wa = 5'd7;  wd = 32'hAA;
        set_en = 1'b1;  set_addr = 5'd8;
        push("split_cycle", S_RBUSY, 128'h0);
        tick();
        we = 1'b0;  set_en = 1'b0;
        push("split_next", S_RBUSY, 128'h2);

        // Asynchronous reset while busy8 is set.
        tick();
        reset = 1'b0;
        push("arst_ready", S_READY, 128'h0);
        push("arst_rbusy", S_RBUSY, 128'h0);
        push("arst_rd", S_RD, 128'h0);
        tick();
        reset = 1'b1;
        for (int i = 1; i <= 9; i++) begin
            tick();
            push("mid_ready", S_READY, 128'h0);
        end
        reset = 1'b0;
        push("mid_arst_ready", S_READY, 128'h0);
        push("mid_arst_rbusy", S_RBUSY, 128'h0);
        tick();
        reset = 1'b1;
        for (int i = 1; i <= 32; i++) begin
            tick();
            push("resweep_ready", S_READY, (i >= 31) ? 128'h1 : 128'h0);
        end
        tick();
        ra = {5'd8, 5'd5};
        push("resweep_rd", S_RD, 128'h0);
        push("resweep_rbusy", S_RBUSY, 128'h0);

        // Small 4-port instance.
        tick();
        reset2 = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            tick();
            push("p4_ready", S_READY2, (i >= 7) ? 128'h1 : 128'h0);
        end
        tick();
        we2 = 1'b1;  wa2 = 3'd3;  wd2 = 32'hA5;
        push("p4_bypass", S_RD2, {4{32'hA5}});
        tick();
        we2 = 1'b0;
        push("p4_stored", S_RD2, {4{32'hA5}});
        push("p4_rbusy", S_RBUSY2, 128'h0);

        for (int i = 0; i < 10 && sb.size() > 0; i++) begin
            @(negedge clk);
        end
        #1;
        if (sb.size() > 0) begin
            $display("FAIL drain: got %0d pending expected 0", sb.size());
            failures += sb.size();
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
